// File: rtl/br_resolve_sched.sv
// Branch-resolution scheduler: serialises two branch-FU resolutions per cycle into
// a one-per-cycle branch_stack port. Optional same-cycle bypass: BR_SCHED_BYPASS_EN.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_MASK_W
`define BR_MASK_W 5
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module br_resolve_sched #(
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                fu_br_valid_i,
    input  logic [2*`BR_STATE_W-1:0]  fu_br_state_i,
    input  logic [2*`BR_MASK_W-1:0]   fu_br_mask_i,
    input  logic [2*`BR_MASK_W-1:0]   fu_br_bit_i,
    input  logic                      flush_i,
    output logic [`BR_STATE_W-1:0]    br_state_o,
    output logic [`BR_MASK_W-1:0]     br_dep_mask_o,
    output logic                      stall_o
);
    localparam int SW = `BR_STATE_W;
    localparam int MW = `BR_MASK_W;
    localparam int IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(MW + 1);

    typedef struct packed {
        logic [SW-1:0] state;
        logic [MW-1:0] mask;
        logic [MW-1:0] bits;
    } br_entry_t;

    function automatic logic [CW-1:0] popcount(input logic [MW-1:0] m);
        popcount = '0;
        for (int k = 0; k < MW; k++) popcount = popcount + CW'(m[k]);
    endfunction

    logic [QDEPTH-1:0] valid_q, valid_d;
    br_entry_t         ent_q [QDEPTH];
    br_entry_t         ent_d [QDEPTH];
    logic              stall_q, stall_d;

    br_entry_t         fu_ent [2];
    logic [1:0]        fu_acc;
    logic [1:0]        enq;
    logic              ent_wrong [QDEPTH];
    logic [CW-1:0]     ent_cnt [QDEPTH];
    logic              sel_found, sel_wrong;
    logic [IW-1:0]     sel_idx;
    logic [CW-1:0]     sel_cnt;
    logic              byp;
    logic              iss_valid, iss_wrong;
    br_entry_t         iss_ent;
    logic [MW-1:0]     clr_bits;
    logic              have0, have1;
    logic [IW-1:0]     slot0, slot1;
    logic [IW:0]       free_cnt;

    // Inputs arriving while stalled violate the protocol and are discarded here.
    assign fu_acc = fu_br_valid_i & {2{~stall_q}};

    always_comb begin
        for (int f = 0; f < 2; f++) begin
            fu_ent[f].state = fu_br_state_i[f*SW +: SW];
            fu_ent[f].mask  = fu_br_mask_i[f*MW +: MW];
            fu_ent[f].bits  = fu_br_bit_i[f*MW +: MW];
        end
    end

    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            ent_wrong[i] = (ent_q[i].state == `BR_PR_WRONG);
            ent_cnt[i]   = popcount(ent_q[i].mask);
        end
    end

    // Mispredicts first, then oldest (fewest dependency bits); strict '<' keeps the lower index on ties.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_wrong = 1'b0;
        sel_cnt   = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (valid_q[i] && (!sel_found
                    || (ent_wrong[i] && !sel_wrong)
                    || (ent_wrong[i] == sel_wrong && ent_cnt[i] < sel_cnt))) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
                sel_wrong = ent_wrong[i];
                sel_cnt   = ent_cnt[i];
            end
        end
    end

    always_comb begin
        iss_valid = sel_found;
        iss_ent   = ent_q[sel_idx];
        byp       = 1'b0;
`ifdef BR_SCHED_BYPASS_EN
        byp = ~(|valid_q) && (fu_acc == 2'b01 || fu_acc == 2'b10);
        if (byp) begin
            iss_valid = 1'b1;
            iss_ent   = fu_acc[0] ? fu_ent[0] : fu_ent[1];
        end
`endif
        iss_wrong = iss_valid && (iss_ent.state == `BR_PR_WRONG);
        clr_bits  = iss_valid ? iss_ent.bits : '0;
    end

    assign br_state_o    = iss_valid ? iss_ent.state : '0;
    assign br_dep_mask_o = iss_valid ? iss_ent.mask  : '0;
    assign stall_o       = stall_q;

    always_comb begin
        have0 = 1'b0;
        have1 = 1'b0;
        slot0 = '0;
        slot1 = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (!valid_q[i]) begin
                if (!have0) begin
                    have0 = 1'b1;
                    slot0 = IW'(i);
                end else if (!have1) begin
                    have1 = 1'b1;
                    slot1 = IW'(i);
                end
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        valid_d = valid_q;
        ent_d   = ent_q;
        for (int i = 0; i < QDEPTH; i++) begin
            if (valid_q[i]) begin
                if (sel_found && !byp && IW'(i) == sel_idx)
                    valid_d[i] = 1'b0;
                else if (iss_wrong && |(ent_q[i].mask & clr_bits))
                    valid_d[i] = 1'b0;
                else
                    ent_d[i].mask = ent_q[i].mask & ~clr_bits;
            end
        end

        for (int f = 0; f < 2; f++)
            enq[f] = fu_acc[f] && !byp && !(iss_wrong && |(fu_ent[f].mask & clr_bits));

        if (enq[0] && have0) begin
            valid_d[slot0] = 1'b1;
            ent_d[slot0]   = '{state: fu_ent[0].state, mask: fu_ent[0].mask & ~clr_bits,
                               bits: fu_ent[0].bits};
        end
        if (enq[1] && (enq[0] ? have1 : have0)) begin
            valid_d[enq[0] ? slot1 : slot0] = 1'b1;
            ent_d[enq[0] ? slot1 : slot0]   = '{state: fu_ent[1].state,
                                               mask: fu_ent[1].mask & ~clr_bits,
                                               bits: fu_ent[1].bits};
        end

        if (flush_i) valid_d = '0;

        free_cnt = '0;
        for (int i = 0; i < QDEPTH; i++) free_cnt = free_cnt + (IW+1)'(~valid_d[i]);
        stall_d = (free_cnt < (IW+1)'(2));
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            stall_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            stall_q <= stall_d;
        end
    end

    // NOTE: payload flops are deliberately not reset; valid_q gates every use of them.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_br_resolve_sched.sv
// Directed self-checking bench for br_resolve_sched (QDEPTH=4, 5-bit masks).
module tb_br_resolve_sched;
    localparam logic [1:0] ST_C = 2'd1;
    localparam logic [1:0] ST_W = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] fu_br_valid_i;
    logic [3:0] fu_br_state_i;
    logic [9:0] fu_br_mask_i;
    logic [9:0] fu_br_bit_i;
    logic       flush_i;
    logic [1:0] br_state_o;
    logic [4:0] br_dep_mask_o;
    logic       stall_o;

    int n_checks = 0;
    int n_errors = 0;

    br_resolve_sched #(.QDEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .fu_br_valid_i (fu_br_valid_i),
        .fu_br_state_i (fu_br_state_i),
        .fu_br_mask_i  (fu_br_mask_i),
        .fu_br_bit_i   (fu_br_bit_i),
        .flush_i       (flush_i),
        .br_state_o    (br_state_o),
        .br_dep_mask_o (br_dep_mask_o),
        .stall_o       (stall_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] st, input logic [4:0] m,
                           input logic stl);
        @(negedge clk);
        check({tag, ".state"}, {6'd0, br_state_o}, {6'd0, st});
        check({tag, ".mask"},  {3'd0, br_dep_mask_o}, {3'd0, m});
        check({tag, ".stall"}, {7'd0, stall_o}, {7'd0, stl});
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        fu_br_valid_i = 2'b00;
        fu_br_state_i = '0;
        fu_br_mask_i  = '0;
        fu_br_bit_i   = '0;
        flush_i       = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic fu(input logic [1:0] v,
                      input logic [1:0] s0, input logic [4:0] m0, input logic [4:0] b0,
                      input logic [1:0] s1, input logic [4:0] m1, input logic [4:0] b1);
        fu_br_valid_i = v;
        fu_br_state_i = {s1, s0};
        fu_br_mask_i  = {m1, m0};
        fu_br_bit_i   = {b1, b0};
    endtask

    // Loads A,B then C,D (all CORRECT); leaves B,C,D queued and stall_o=1 in the next cycle.
    task automatic fill_three();
        tick(); fu(2'b11, ST_C, 5'b00001, 5'b00001, ST_C, 5'b00011, 5'b00010);
        chk_out("fill.c1", 2'd0, 5'b00000, 1'b0);
        tick(); fu(2'b11, ST_C, 5'b00111, 5'b00100, ST_C, 5'b01111, 5'b01000);
        chk_out("fill.c2", ST_C, 5'b00001, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        fu(2'b00, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 5'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset.state", {6'd0, br_state_o}, 8'd0);
        check("reset.mask",  {3'd0, br_dep_mask_o}, 8'd0);
        check("reset.stall", {7'd0, stall_o}, 8'd0);

        // Single input, base latency (or same-cycle with bypass).
        tick(); fu(2'b01, ST_C, 5'b00011, 5'b00010, 2'd0, 5'd0, 5'd0);
`ifdef BR_SCHED_BYPASS_EN
        chk_out("single.n",  ST_C, 5'b00011, 1'b0);
        tick(); chk_out("single.n1", 2'd0, 5'b00000, 1'b0);
`else
        chk_out("single.n",  2'd0, 5'b00000, 1'b0);
        tick(); chk_out("single.n1", ST_C, 5'b00011, 1'b0);
`endif
        tick(); chk_out("single.n2", 2'd0, 5'b00000, 1'b0);

        // Dual CORRECT: oldest first, then bit clearing on the survivor.
        tick(); fu(2'b11, ST_C, 5'b00111, 5'b00100, ST_C, 5'b00011, 5'b00010);
        chk_out("dual.n",  2'd0, 5'b00000, 1'b0);
        tick(); chk_out("dual.n1", ST_C, 5'b00011, 1'b0);
        tick(); chk_out("dual.n2", ST_C, 5'b00101, 1'b0);
        tick(); chk_out("dual.n3", 2'd0, 5'b00000, 1'b0);

        // Mispredict beats older CORRECT, squashes it and a same-cycle dependent input.
        tick(); fu(2'b11, ST_C, 5'b10000, 5'b10000, ST_C, 5'b01111, 5'b01000);
        chk_out("wrong.n",  2'd0, 5'b00000, 1'b0);
        tick(); fu(2'b10, 2'd0, 5'd0, 5'd0, ST_W, 5'b00011, 5'b00010);
        chk_out("wrong.n1", ST_C, 5'b10000, 1'b0);
        tick(); fu(2'b01, ST_C, 5'b00110, 5'b00100, 2'd0, 5'd0, 5'd0);
        chk_out("wrong.n2", ST_W, 5'b00011, 1'b0);
        tick(); chk_out("wrong.n3", 2'd0, 5'b00000, 1'b0);
        tick(); chk_out("wrong.n4", 2'd0, 5'b00000, 1'b0);

        // Full/stall: stalled-cycle inputs must vanish.
        fill_three();
        tick(); fu(2'b11, ST_C, 5'b10000, 5'b10000, ST_W, 5'b10000, 5'b10000);
        chk_out("stall.c3", ST_C, 5'b00010, 1'b1);
        tick(); chk_out("stall.c4", ST_C, 5'b00100, 1'b0);
        tick(); chk_out("stall.c5", ST_C, 5'b01000, 1'b0);
        tick(); chk_out("stall.c6", 2'd0, 5'b00000, 1'b0);

        // Flush with three entries queued.
        fill_three();
        tick(); flush_i = 1'b1;
        chk_out("flush.c3", ST_C, 5'b00010, 1'b1);
        tick(); chk_out("flush.c4", 2'd0, 5'b00000, 1'b0);
        tick(); chk_out("flush.c5", 2'd0, 5'b00000, 1'b0);

        // Same with reset in place of flush.
        fill_three();
        tick(); rst = 1'b1;
        chk_out("rst.c3", ST_C, 5'b00010, 1'b1);
        tick(); chk_out("rst.c4", 2'd0, 5'b00000, 1'b0);
        tick(); chk_out("rst.c5", 2'd0, 5'b00000, 1'b0);

        // Flush discards same-cycle FU inputs.
        tick(); fu(2'b11, ST_C, 5'b00001, 5'b00001, ST_C, 5'b00011, 5'b00010);
        chk_out("flin.c1", 2'd0, 5'b00000, 1'b0);
        tick(); fu(2'b11, ST_C, 5'b00111, 5'b00100, ST_C, 5'b01111, 5'b01000);
        flush_i = 1'b1;
        chk_out("flin.c2", ST_C, 5'b00001, 1'b0);
        tick(); chk_out("flin.c3", 2'd0, 5'b00000, 1'b0);
        tick(); chk_out("flin.c4", 2'd0, 5'b00000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
